// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: load-store priority, lock until accept,
// and an in-order id FIFO that steers responses back to their requester.
module mem_port_arbiter #(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  state_e               state_q;
  logic                 lock_id_q;
  logic [MAX_OUTST-1:0] ids_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [PW-1:0]        wr_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 arb_err_q;

  logic grant_id;
  logic full;
  logic hs;
  logic pop;
  logic head;
  logic req_sel;

  assign grant_id = (state_q == LOCK) ? lock_id_q : data_req;
  assign full     = (cnt_q == CW'(MAX_OUTST));
  assign req_sel  = grant_id ? data_req : inst_req;
  assign mem_req  = req_sel & ~full;
  assign hs       = mem_req & mem_addr_ok;
  assign pop      = mem_data_ok & (cnt_q != '0);
  assign head     = ids_q[rd_ptr_q];

  assign mem_wr    = grant_id ? data_wr    : inst_wr;
  assign mem_size  = grant_id ? data_size  : inst_size;
  assign mem_wstrb = grant_id ? data_wstrb : inst_wstrb;
  assign mem_addr  = grant_id ? data_addr  : inst_addr;
  assign mem_wdata = grant_id ? data_wdata : inst_wdata;

  assign inst_addr_ok = hs & ~grant_id;
  assign data_addr_ok = hs &  grant_id;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop &  head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_err      = arb_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      lock_id_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_req && !mem_addr_ok) begin
            state_q   <= LOCK;
            lock_id_q <= grant_id;
          end
        end
        LOCK: begin
          if (hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap for free because MAX_OUTST is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ids_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      arb_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (hs) begin
        ids_q[wr_ptr_q] <= grant_id;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (mem_data_ok && cnt_q == '0) arb_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based model.
// Directed steps cover reset, spurious responses and the lock rule.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int nchk;
  int nfail;

  int q[$];
  bit m_locked;
  bit m_owner;
  bit m_err;

  mem_port_arbiter #(.MAX_OUTST(MAX)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic rand_payload();
    inst_wr    = 1'($urandom);
    inst_size  = 2'($urandom_range(0, 2));
    inst_addr  = $urandom;
    inst_wstrb = 4'($urandom);
    inst_wdata = $urandom;
    data_wr    = 1'($urandom);
    data_size  = 2'($urandom_range(0, 2));
    data_addr  = $urandom;
    data_wstrb = 4'($urandom);
    data_wdata = $urandom;
    mem_rdata  = $urandom;
  endtask

  task automatic model_clear();
    q.delete();
    m_locked = 0;
    m_owner  = 0;
    m_err    = 0;
  endtask

  // Drive one cycle at negedge, check outputs, then advance the model.
  task automatic step(input bit ir, input bit dr,
                      input bit aok, input bit dok);
    bit g, mreq, hs, idok, ddok;
    rand_payload();
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    #1;
    g    = m_locked ? m_owner : dr;
    mreq = (g ? dr : ir) && (q.size() < MAX);
    hs   = mreq && aok;
    idok = dok && q.size() > 0 && q[0] == 0;
    ddok = dok && q.size() > 0 && q[0] == 1;
    chk("mem_req", 32'(mem_req), 32'(mreq));
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(hs && !g));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(hs && g));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(idok));
    chk("data_data_ok", 32'(data_data_ok), 32'(ddok));
    chk("arb_err", 32'(arb_err), 32'(m_err));
    chk("mem_addr", mem_addr, g ? data_addr : inst_addr);
    chk("mem_wdata", mem_wdata, g ? data_wdata : inst_wdata);
    chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
        g ? {25'd0, data_wr, data_size, data_wstrb}
          : {25'd0, inst_wr, inst_size, inst_wstrb});
    chk("rdata", {inst_rdata ^ mem_rdata}, 32'd0);
    chk("rdata_d", data_rdata, mem_rdata);
    @(posedge clk);
    if (dok) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1;
    end
    if (hs) q.push_back(int'(g));
    if (!m_locked && mreq && !aok) begin
      m_locked = 1;
      m_owner  = g;
    end else if (m_locked && hs) begin
      m_locked = 0;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; checked before any clock.
  task automatic async_reset(input bit ir);
    inst_req    = ir;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_clear();
    chk("rst_arb_err", 32'(arb_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'(ir));
    chk("rst_addr_ok", 32'(inst_addr_ok | data_addr_ok), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    model_clear();
    rand_payload();
    resetn      = 1'b0;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    #3;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_arb_err", 32'(arb_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Priority, then fetch after data drops.
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    // Fetch locked while data rises.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    // Fill to full, pending req blocked, drain in order.
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < MAX + 1; i++) step(1, 0, 1, 1);
    for (int i = 0; i < MAX + 2; i++) step(0, 0, 0, 1);

    // Spurious response and sticky error.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    // Mid-transaction reset with outstanding ids.
    async_reset(1'b0);
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    async_reset(1'b1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      if (i % 300 == 150) async_reset(1'($urandom));
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 4,
           1'($urandom),
           q.size() > 0 ? ($urandom_range(0, 99) < 40)
                        : ($urandom_range(0, 99) < 2));
    end

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
